// File: rtl/mmio_controller.sv
// mmio_controller: decodes processor data accesses into data RAM or a small
// I/O register window, gates RAM writes and returns load data with the same
// one-cycle latency as the RAM.
//
// Ports:
//   clock         system clock, all logic on posedge
//   reset         asynchronous active-low reset
//   address_dmem  processor data word address
//   data          processor store data
//   wren          processor store enable
//   rden          processor load enable
//   ram_q         data RAM read data (1-cycle latency)
//   ram_wren      RAM write enable, suppressed for I/O addresses
//   q_dmem        load data back to processor
//   sw            raw board switches
//   led           LED register
//   key_valid     one-cycle strobe of a new PS/2 scan code
//   key_code      scan code qualified by key_valid
//   audio_note    note select for the audio controller
//   audio_en      audio enable
module mmio_controller #(
    parameter int IO_BASE    = 4096,
    parameter int FIFO_DEPTH = 8,
    parameter int SW_WIDTH   = 16,
    parameter int LED_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          address_dmem,
    input  logic [31:0]          data,
    input  logic                 wren,
    input  logic                 rden,
    input  logic [31:0]          ram_q,
    output logic                 ram_wren,
    output logic [31:0]          q_dmem,
    input  logic [SW_WIDTH-1:0]  sw,
    output logic [LED_WIDTH-1:0] led,
    input  logic                 key_valid,
    input  logic [7:0]           key_code,
    output logic [7:0]           audio_note,
    output logic                 audio_en
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] BASE = 32'(IO_BASE);

    logic [31:0]         offset;
    logic                io_sel;
    logic                wr_io;
    logic                rd_io;
    logic                wr_led;
    logic                wr_stat;
    logic                wr_audio;
    logic                pop_req;
    logic                empty;
    logic                full;
    logic                do_pop;
    logic                do_push;
    logic                drop;
    logic [7:0]          head;
    logic [31:0]         io_rdata_d;
    logic [31:0]         status;
    logic                unused_data;

    logic [SW_WIDTH-1:0] sw_s1;
    logic [SW_WIDTH-1:0] sw_s2;
    logic                sel_q;
    logic [31:0]         io_rdata_q;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                overflow;
    logic [7:0]          mem [FIFO_DEPTH];

    // Offset is only meaningful once the address is known to be >= BASE,
    // so the unsigned subtraction never wraps inside the window.
    assign offset   = address_dmem - BASE;
    assign io_sel   = (address_dmem >= BASE) && (offset <= 32'd4);
    assign ram_wren = wren & ~io_sel;

    // Stores win over loads for side effects, so a load only acts when no
    // store is present in the same cycle.
    assign wr_io    = wren & io_sel;
    assign rd_io    = rden & ~wren & io_sel;
    assign wr_led   = wr_io & (offset[2:0] == 3'd1);
    assign wr_stat  = wr_io & (offset[2:0] == 3'd2);
    assign wr_audio = wr_io & (offset[2:0] == 3'd4);
    assign pop_req  = rd_io & (offset[2:0] == 3'd3);

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign do_pop   = pop_req & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds and nothing is dropped.
    assign do_push  = key_valid & (~full | do_pop);
    assign drop     = key_valid & full & ~do_pop;
    assign head     = mem[rd_ptr];

    assign status   = {23'd0, 5'(count), 1'b0, full, overflow, ~empty};

    always_comb begin
        io_rdata_d = '0;
        if (io_sel) begin
            case (offset[2:0])
                3'd0:    io_rdata_d = 32'(sw_s2);
                3'd1:    io_rdata_d = 32'(led);
                3'd2:    io_rdata_d = status;
                3'd3:    io_rdata_d = empty ? 32'd0 : {24'd0, head};
                3'd4:    io_rdata_d = {23'd0, audio_en, audio_note};
                default: io_rdata_d = '0;
            endcase
        end
    end

    assign q_dmem = sel_q ? io_rdata_q : ram_q;

    // Upper store-data bits have no destination register.
    assign unused_data = ^data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_s1      <= '0;
            sw_s2      <= '0;
            sel_q      <= 1'b0;
            io_rdata_q <= '0;
            led        <= '0;
            audio_note <= '0;
            audio_en   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            sw_s1      <= sw;
            sw_s2      <= sw_s1;
            sel_q      <= io_sel;
            io_rdata_q <= io_rdata_d;
            if (wr_led)
                led <= data[LED_WIDTH-1:0];
            if (wr_audio) begin
                audio_note <= data[7:0];
                audio_en   <= data[8];
            end
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
            // A drop in the same cycle as a clear leaves overflow set.
            if (drop)
                overflow <= 1'b1;
            else if (wr_stat)
                overflow <= 1'b0;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= key_code;
    end
endmodule

// File: tb/tb_mmio_controller.sv
// tb_mmio_controller: directed vector table plus hand sequences for the
// FIFO, overflow, synchronizer and asynchronous reset corner cases.
module tb_mmio_controller;
    localparam logic [31:0] RAMQ = 32'hCAFE_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic [31:0] ram_q = RAMQ;
    logic        ram_wren;
    logic [31:0] q_dmem;
    logic [15:0] sw = '0;
    logic [15:0] led;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = '0;
    logic [7:0]  audio_note;
    logic        audio_en;

    int n_cmp = 0;
    int n_bad = 0;

    mmio_controller dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
        .wren(wren), .rden(rden), .ram_q(ram_q), .ram_wren(ram_wren),
        .q_dmem(q_dmem), .sw(sw), .led(led), .key_valid(key_valid),
        .key_code(key_code), .audio_note(audio_note), .audio_en(audio_en)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] dat;
        logic        kv;
        logic [7:0]  kc;
        logic        exp_rw;
        logic        chk_q;
        logic [31:0] exp_q;
        logic [15:0] exp_led;
        logic [8:0]  exp_aud;
    } vec_t;

    vec_t v [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic kv, input logic [7:0] kc);
        wren = w; rden = r; address_dmem = a; data = d; key_valid = kv; key_code = kc;
        @(posedge clock);
        #1;
        wren = 1'b0; rden = 1'b0; address_dmem = '0; data = '0; key_valid = 1'b0; key_code = '0;
    endtask

    initial begin
        //                 wr rd addr  data        kv kc     rw chk q            led       aud
        v.push_back(vec_t'{1, 0, 4097, 32'hA5A5,   0, 8'h00, 0, 0, 32'h0,        16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 1, 4097, 32'h0,      0, 8'h00, 0, 1, 32'h0000A5A5, 16'hA5A5, 9'h000});
        v.push_back(vec_t'{1, 0, 100,  32'h5,      0, 8'h00, 1, 1, RAMQ,         16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 1, 100,  32'h0,      0, 8'h00, 0, 1, RAMQ,         16'hA5A5, 9'h000});
        v.push_back(vec_t'{1, 0, 4101, 32'h1,      0, 8'h00, 1, 1, RAMQ,         16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 1, 4101, 32'h0,      0, 8'h00, 0, 1, RAMQ,         16'hA5A5, 9'h000});
        v.push_back(vec_t'{1, 0, 4095, 32'h1,      0, 8'h00, 1, 1, RAMQ,         16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 0, 0,    32'h0,      1, 8'h1C, 0, 1, RAMQ,         16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 0, 0,    32'h0,      1, 8'h32, 0, 1, RAMQ,         16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 0, 0,    32'h0,      1, 8'h21, 0, 1, RAMQ,         16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 1, 4098, 32'h0,      0, 8'h00, 0, 1, 32'h31,       16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 1, 4099, 32'h0,      0, 8'h00, 0, 1, 32'h1C,       16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 1, 4099, 32'h0,      0, 8'h00, 0, 1, 32'h32,       16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 1, 4099, 32'h0,      0, 8'h00, 0, 1, 32'h21,       16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 1, 4098, 32'h0,      0, 8'h00, 0, 1, 32'h00,       16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 1, 4099, 32'h0,      0, 8'h00, 0, 1, 32'h00,       16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 1, 4098, 32'h0,      0, 8'h00, 0, 1, 32'h00,       16'hA5A5, 9'h000});
        v.push_back(vec_t'{1, 0, 4099, 32'h77,     0, 8'h00, 0, 0, 32'h0,        16'hA5A5, 9'h000});
        v.push_back(vec_t'{0, 1, 4098, 32'h0,      0, 8'h00, 0, 1, 32'h00,       16'hA5A5, 9'h000});
        v.push_back(vec_t'{1, 0, 4100, 32'h145,    0, 8'h00, 0, 0, 32'h0,        16'hA5A5, 9'h145});
        v.push_back(vec_t'{0, 1, 4100, 32'h0,      0, 8'h00, 0, 1, 32'h145,      16'hA5A5, 9'h145});
        v.push_back(vec_t'{1, 0, 4096, 32'hFFFF,   0, 8'h00, 0, 0, 32'h0,        16'hA5A5, 9'h145});
        v.push_back(vec_t'{0, 1, 4096, 32'h0,      0, 8'h00, 0, 1, 32'h0,        16'hA5A5, 9'h145});

        repeat (3) @(posedge clock);
        #1;
        chk("reset led", 32'(led), 32'h0);
        chk("reset audio", {23'd0, audio_en, audio_note}, 32'h0);
        chk("reset q_dmem", q_dmem, RAMQ);
        reset = 1'b1;

        foreach (v[i]) begin
            wren = v[i].wr; rden = v[i].rd; address_dmem = v[i].addr; data = v[i].dat;
            key_valid = v[i].kv; key_code = v[i].kc;
            #1;
            chk($sformatf("v%0d ram_wren", i), 32'(ram_wren), 32'(v[i].exp_rw));
            @(posedge clock);
            #1;
            if (v[i].chk_q)
                chk($sformatf("v%0d q_dmem", i), q_dmem, v[i].exp_q);
            chk($sformatf("v%0d led", i), 32'(led), 32'(v[i].exp_led));
            chk($sformatf("v%0d audio", i), {23'd0, audio_en, audio_note}, 32'(v[i].exp_aud));
        end
        wren = 1'b0; rden = 1'b0; address_dmem = '0; data = '0; key_valid = 1'b0;

        // switch synchronizer
        #2 sw = 16'h1234;
        repeat (3) @(posedge clock);
        #1;
        cyc(0, 1, 4096, 0, 0, 0);
        chk("sw sync", q_dmem, 32'h1234);

        // overflow on ninth push, then clear
        for (int i = 1; i <= 9; i++) cyc(0, 0, 0, 0, 1, 8'(i));
        cyc(0, 1, 4098, 0, 0, 0);
        chk("status full ovf", q_dmem, 32'h87);
        cyc(1, 0, 4098, 0, 0, 0);
        cyc(0, 1, 4098, 0, 0, 0);
        chk("status ovf cleared", q_dmem, 32'h85);

        // push and pop together while full
        cyc(0, 1, 4099, 0, 1, 8'hAA);
        chk("full push+pop head", q_dmem, 32'h01);
        cyc(0, 1, 4098, 0, 0, 0);
        chk("full push+pop status", q_dmem, 32'h85);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 4099, 0, 0, 0);
            chk($sformatf("drain %0d", i), q_dmem, (i < 7) ? 32'(i + 2) : 32'hAA);
        end
        cyc(0, 1, 4098, 0, 0, 0);
        chk("drained status", q_dmem, 32'h00);

        // push and pop together while empty
        cyc(0, 1, 4099, 0, 1, 8'h55);
        chk("empty push+pop q", q_dmem, 32'h00);
        cyc(0, 1, 4098, 0, 0, 0);
        chk("empty push+pop status", q_dmem, 32'h11);
        cyc(0, 1, 4099, 0, 0, 0);
        chk("empty push+pop data", q_dmem, 32'h55);

        // drop and clear in the same cycle: overflow stays set
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 8'(8'h60 + i));
        cyc(1, 0, 4098, 0, 1, 8'h99);
        cyc(0, 1, 4098, 0, 0, 0);
        chk("set wins", q_dmem, 32'h87);

        // asynchronous reset in the middle of a push burst
        cyc(1, 0, 4097, 32'h00FF, 0, 0);
        chk("led pre-reset", 32'(led), 32'h00FF);
        key_valid = 1'b1; key_code = 8'h40;
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("async led", 32'(led), 32'h0);
        chk("async audio", {23'd0, audio_en, audio_note}, 32'h0);
        chk("async q_dmem", q_dmem, RAMQ);
        repeat (2) @(posedge clock);
        #1;
        key_valid = 1'b0;
        reset = 1'b1;
        cyc(0, 1, 4098, 0, 0, 0);
        chk("post-reset status", q_dmem, 32'h00);
        cyc(0, 0, 0, 0, 1, 8'h12);
        cyc(0, 1, 4098, 0, 0, 0);
        chk("post-reset push", q_dmem, 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
